// File: rtl/cgra_loader_pkg.sv
// Shared types and constants for the CGRA AXI loader.
//   loader_state_e : loader FSM states
//   status_e       : completion code returned to the core
//   AXI_*          : fixed AXI4 encodings used by the write initiator
package cgra_loader_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StAw,
        StW,
        StB,
        StRun,
        StReport
    } loader_state_e;

    typedef enum logic [1:0] {
        StatusOk      = 2'd0,
        StatusAxiErr  = 2'd1,
        StatusCgraErr = 2'd2,
        StatusTimeout = 2'd3
    } status_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/cgra_burst_len.sv
// Combinational burst-length calculator.
//   word_ofs_i : address bits [11:2] (word offset inside the current 4 KB page)
//   remain_i   : words still to transfer
//   len_o      : beats in the next burst = min(remain, MAX_BURST, words left in page)
module cgra_burst_len #(
    parameter int unsigned MAX_BURST = 16
) (
    input  logic [9:0]  word_ofs_i,
    input  logic [15:0] remain_i,
    output logic [8:0]  len_o
);

    localparam logic [16:0] MaxBeats = 17'(MAX_BURST);

    logic [16:0] to_page_end;
    logic [16:0] len_full;
    logic        unused_len_hi;

    always_comb begin
        // Words left before the next 4 KB boundary: 1..1024.
        to_page_end = 17'd1024 - {7'd0, word_ofs_i};
        len_full    = {1'b0, remain_i};
        if (len_full > MaxBeats) begin
            len_full = MaxBeats;
        end
        if (len_full > to_page_end) begin
            len_full = to_page_end;
        end
    end

    // MAX_BURST <= 256 keeps the result within 9 bits.
    assign len_o         = len_full[8:0];
    assign unused_len_hi = ^len_full[16:9];

endmodule

// File: rtl/cgra_axi_loader.sv
// Host-side loader for the CGRA: accepts a load command, writes cmd_len words from the
// src_* stream into the CGRA AXI4 slave as INCR bursts (never crossing 4 KB), then raises
// Start and waits for Done/Error, returning one status code with a status_valid pulse.
// Ports: cmd_* command handshake; src_* payload stream (passed straight to W);
//        axi_*_CGRA AW/W/B write channels; Start/Done/Error CGRA control;
//        busy, status, status_valid to the core.
// Optional: define CGRA_LOADER_TIMEOUT_EN to abort RUN after TIMEOUT_CYC cycles (status 3).
module cgra_axi_loader
    import cgra_loader_pkg::*;
#(
    parameter int unsigned MAX_BURST   = 16,
    parameter logic [3:0]  AXI_ID      = 4'h1,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_addr,
    input  logic [15:0] cmd_len,
    input  logic [31:0] src_data,
    input  logic        src_valid,
    output logic        src_ready,
    output logic [3:0]  axi_awid_CGRA,
    output logic [31:0] axi_awaddr_CGRA,
    output logic [7:0]  axi_awlen_CGRA,
    output logic [2:0]  axi_awsize_CGRA,
    output logic [1:0]  axi_awburst_CGRA,
    output logic        axi_awvalid_CGRA,
    input  logic        axi_awready_CGRA,
    output logic [31:0] axi_wdata_CGRA,
    output logic [3:0]  axi_wstrb_CGRA,
    output logic        axi_wlast_CGRA,
    output logic        axi_wvalid_CGRA,
    input  logic        axi_wready_CGRA,
    input  logic [3:0]  axi_bid_CGRA,
    input  logic [1:0]  axi_bresp_CGRA,
    input  logic        axi_bvalid_CGRA,
    output logic        axi_bready_CGRA,
    output logic        Start,
    input  logic        Done,
    input  logic [1:0]  Error,
    output logic        busy,
    output logic [1:0]  status,
    output logic        status_valid
);

    loader_state_e state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic [15:0]   remain_q, remain_d;
    logic [7:0]    beat_q, beat_d;
    status_e       status_q, status_d;

    logic [8:0]    burst_len;
    logic [8:0]    awlen_full;
    logic          last_beat;
    logic          tmo_hit;
    logic          unused_ok;

    cgra_burst_len #(
        .MAX_BURST (MAX_BURST)
    ) u_burst_len (
        .word_ofs_i (addr_q[11:2]),
        .remain_i   (remain_q),
        .len_o      (burst_len)
    );

    assign awlen_full = burst_len - 9'd1;
    assign last_beat  = (beat_q == awlen_full[7:0]);

`ifdef CGRA_LOADER_TIMEOUT_EN
    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYC - 1);

    logic [15:0] tmo_cnt_q, tmo_cnt_d;

    // Zero outside RUN, so it is clear on the first RUN cycle.
    assign tmo_cnt_d = (state_q == StRun) ? tmo_cnt_q + 16'd1 : 16'd0;
    assign tmo_hit   = (state_q == StRun) && (tmo_cnt_q == TimeoutLast);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_q <= 16'd0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    logic unused_tmo;
    assign tmo_hit    = 1'b0;
    assign unused_tmo = ^TIMEOUT_CYC;
`endif

    assign axi_awid_CGRA    = AXI_ID;
    assign axi_awsize_CGRA  = AXI_SIZE_4B;
    assign axi_awburst_CGRA = AXI_BURST_INCR;
    assign status           = status_q;
    assign busy             = (state_q != StIdle);
    assign unused_ok        = ^{axi_bid_CGRA, cmd_addr[1:0], awlen_full[8]};

    always_comb begin
        state_d          = state_q;
        addr_d           = addr_q;
        remain_d         = remain_q;
        beat_d           = beat_q;
        status_d         = status_q;
        cmd_ready        = 1'b0;
        src_ready        = 1'b0;
        axi_awaddr_CGRA  = 32'd0;
        axi_awlen_CGRA   = 8'd0;
        axi_awvalid_CGRA = 1'b0;
        axi_wdata_CGRA   = 32'd0;
        axi_wstrb_CGRA   = 4'h0;
        axi_wlast_CGRA   = 1'b0;
        axi_wvalid_CGRA  = 1'b0;
        axi_bready_CGRA  = 1'b0;
        Start            = 1'b0;
        status_valid     = 1'b0;

        case (state_q)
            StIdle: begin
                // No command is accepted while reset is held.
                cmd_ready = !rst;
                if (cmd_valid) begin
                    addr_d   = {cmd_addr[31:2], 2'b00};
                    remain_d = cmd_len;
                    beat_d   = 8'd0;
                    state_d  = (cmd_len == 16'd0) ? StRun : StAw;
                end
            end
            StAw: begin
                axi_awvalid_CGRA = 1'b1;
                axi_awaddr_CGRA  = addr_q;
                axi_awlen_CGRA   = awlen_full[7:0];
                if (axi_awready_CGRA) begin
                    state_d = StW;
                end
            end
            StW: begin
                axi_wdata_CGRA  = src_data;
                axi_wvalid_CGRA = src_valid;
                src_ready       = axi_wready_CGRA;
                axi_wstrb_CGRA  = 4'hF;
                axi_wlast_CGRA  = last_beat;
                if (src_valid && axi_wready_CGRA) begin
                    if (last_beat) begin
                        beat_d  = 8'd0;
                        state_d = StB;
                    end else begin
                        beat_d = beat_q + 8'd1;
                    end
                end
            end
            StB: begin
                axi_bready_CGRA = 1'b1;
                if (axi_bvalid_CGRA) begin
                    if (axi_bresp_CGRA == AXI_RESP_OKAY) begin
                        addr_d   = addr_q + {21'd0, burst_len, 2'b00};
                        remain_d = remain_q - {7'd0, burst_len};
                        state_d  = (remain_d != 16'd0) ? StAw : StRun;
                    end else begin
                        // Abandon the rest of the load; the CGRA is never started.
                        status_d = StatusAxiErr;
                        state_d  = StReport;
                    end
                end
            end
            StRun: begin
                Start = 1'b1;
                if (Done) begin
                    status_d = (Error == 2'd0) ? StatusOk : StatusCgraErr;
                    state_d  = StReport;
                end else if (tmo_hit) begin
                    status_d = StatusTimeout;
                    state_d  = StReport;
                end
            end
            StReport: begin
                status_valid = 1'b1;
                state_d      = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            addr_q   <= 32'd0;
            remain_q <= 16'd0;
            beat_q   <= 8'd0;
            status_q <= StatusOk;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
            beat_q   <= beat_d;
            status_q <= status_d;
        end
    end

endmodule

// File: tb/tb_cgra_axi_loader.sv
// Self-checking bench for cgra_axi_loader: a table of load commands (directed plus random)
// is run against a randomly stalling AXI slave, source and CGRA; bursts, data order, wlast,
// handshake latencies and the returned status are compared with a reference plan.
module tb_cgra_axi_loader;

    localparam int MaxBurst   = 16;
    localparam int TimeoutCyc = 20;
    localparam int Budget     = 3000;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready;
    logic [31:0] cmd_addr;
    logic [15:0] cmd_len;
    logic [31:0] src_data;
    logic        src_valid, src_ready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid, bready;
    logic        start_o, done_i;
    logic [1:0]  error_i;
    logic        busy;
    logic [1:0]  status;
    logic        status_valid;

    cgra_axi_loader #(
        .MAX_BURST   (MaxBurst),
        .AXI_ID      (4'h1),
        .TIMEOUT_CYC (TimeoutCyc)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_addr         (cmd_addr),
        .cmd_len          (cmd_len),
        .src_data         (src_data),
        .src_valid        (src_valid),
        .src_ready        (src_ready),
        .axi_awid_CGRA    (awid),
        .axi_awaddr_CGRA  (awaddr),
        .axi_awlen_CGRA   (awlen),
        .axi_awsize_CGRA  (awsize),
        .axi_awburst_CGRA (awburst),
        .axi_awvalid_CGRA (awvalid),
        .axi_awready_CGRA (awready),
        .axi_wdata_CGRA   (wdata),
        .axi_wstrb_CGRA   (wstrb),
        .axi_wlast_CGRA   (wlast),
        .axi_wvalid_CGRA  (wvalid),
        .axi_wready_CGRA  (wready),
        .axi_bid_CGRA     (bid),
        .axi_bresp_CGRA   (bresp),
        .axi_bvalid_CGRA  (bvalid),
        .axi_bready_CGRA  (bready),
        .Start            (start_o),
        .Done             (done_i),
        .Error            (error_i),
        .busy             (busy),
        .status           (status),
        .status_valid     (status_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          len;
        int          err_burst;   // burst index answered with SLVERR, -1 for none
        int          done_delay;  // RUN cycle index on which Done pulses
        logic [1:0]  cgra_err;
        int          exp_bursts;  // -1: take from the reference plan
        int          exp_status;  // -1: take from the reference rules
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        int          len;
    } burst_t;

    int     checks = 0;
    int     errors = 0;
    burst_t exp_q[$];
    vec_t   vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference burst plan: greedy split by remaining words, MaxBurst and the 4 KB page.
    task automatic plan_bursts(input logic [31:0] addr, input int len);
        longint a;
        int     r;
        int     room;
        int     n;
        a = longint'(addr & 32'hFFFF_FFFC);
        r = len;
        exp_q.delete();
        while (r > 0) begin
            room = (4096 - int'(a % 4096)) / 4;
            n = r;
            if (n > MaxBurst) n = MaxBurst;
            if (n > room) n = room;
            exp_q.push_back('{a[31:0], n});
            a += 4 * n;
            r -= n;
        end
    endtask

    task automatic run_txn(input vec_t v, input int tag);
        logic [31:0] words[$];
        int     src_idx = 0, rx_idx = 0, aw_cnt = 0, wlast_cnt = 0, b_cnt = 0, pend_b = 0;
        int     run_cyc = 0, beat = 0, cur_len = 0, done_cyc = -1, exp_words = 0;
        int     bad_aw = 0, bad_data = 0, bad_wlast = 0, bad_timing = 0;
        int     n_aw, exp_status, exp_run;
        bit     axi_fail, tmo, saw_status = 0, aw_next = 0, start_next = 0;
        bit     src_hs = 0, b_hs = 0, exp_last;
        logic [1:0] got_status = 2'd0;

        plan_bursts(v.addr, v.len);
        for (int i = 0; i < v.len; i++) words.push_back($urandom);
        axi_fail = (v.err_burst >= 0) && (v.err_burst < exp_q.size());
        n_aw     = axi_fail ? v.err_burst + 1 : exp_q.size();
        for (int i = 0; i < n_aw; i++) exp_words += exp_q[i].len;
        tmo = 1'b0;
`ifdef CGRA_LOADER_TIMEOUT_EN
        tmo = !axi_fail && (v.done_delay >= TimeoutCyc);
`endif
        exp_status = axi_fail ? 1 : tmo ? 3 : (v.cgra_err == 2'd0) ? 0 : 2;
        if (v.exp_status >= 0) exp_status = v.exp_status;
        exp_run = axi_fail ? 0 : tmo ? TimeoutCyc : v.done_delay + 1;

        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_addr  = v.addr;
        cmd_len   = v.len[15:0];
        #1 check($sformatf("v%0d_cmd_ready", tag), cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_addr  = $urandom;
        check($sformatf("v%0d_accept_latency", tag), (v.len == 0) ? start_o : awvalid, 1);

        for (int cyc = 0; cyc < Budget && !saw_status; cyc++) begin
            if (cyc > 0) @(negedge clk);
            awready = ($urandom_range(0, 1) == 1);
            wready  = ($urandom_range(0, 9) < 7);
            if (!src_valid || src_hs) begin
                src_valid = (src_idx < words.size()) && ($urandom_range(0, 9) < 7);
                src_data  = (src_idx < words.size()) ? words[src_idx] : $urandom;
            end
            if (!bvalid || b_hs) begin
                bvalid = (pend_b > 0) && ($urandom_range(0, 1) == 1);
                bresp  = (b_cnt == v.err_burst) ? 2'b10 : 2'b00;
                bid    = 4'($urandom);
            end
            done_i  = start_o && (run_cyc == v.done_delay);
            error_i = done_i ? v.cgra_err : 2'($urandom);
            #1;
            if (aw_next && !awvalid) bad_timing++;
            if (start_next && !start_o) bad_timing++;
            aw_next    = 1'b0;
            start_next = 1'b0;
            if (awvalid && awready) begin
                if (aw_cnt >= exp_q.size() || awaddr !== exp_q[aw_cnt].addr ||
                    int'(awlen) + 1 != exp_q[aw_cnt].len || awsize !== 3'd2 ||
                    awburst !== 2'd1 || awid !== 4'h1) bad_aw++;
                cur_len = int'(awlen) + 1;
                beat    = 0;
                aw_cnt++;
            end
            if (wvalid && wready) begin
                if (rx_idx >= words.size() || wdata !== words[rx_idx] || wstrb !== 4'hF)
                    bad_data++;
                rx_idx++;
                exp_last = (beat == cur_len - 1);
                if (wlast !== exp_last) bad_wlast++;
                if (wlast) wlast_cnt++;
                if (exp_last) pend_b++;
                beat++;
            end
            src_hs = src_valid && src_ready;
            if (src_hs) src_idx++;
            b_hs = bvalid && bready;
            if (b_hs) begin
                pend_b--;
                b_cnt++;
                if (bresp == 2'b00) begin
                    if (b_cnt < exp_q.size()) aw_next = 1'b1;
                    else start_next = 1'b1;
                end
            end
            if (start_o && done_i) done_cyc = cyc;
            if (status_valid) begin
                saw_status = 1'b1;
                got_status = status;
                check($sformatf("v%0d_start_low_at_report", tag), start_o, 0);
                if (!axi_fail && !tmo)
                    check($sformatf("v%0d_report_after_done", tag), cyc, done_cyc + 1);
            end
            if (start_o) run_cyc++;
        end

        check($sformatf("v%0d_completed_in_budget", tag), saw_status, 1);
        check($sformatf("v%0d_aw_count", tag), aw_cnt,
              (v.exp_bursts >= 0) ? v.exp_bursts : n_aw);
        check($sformatf("v%0d_aw_fields", tag), bad_aw, 0);
        check($sformatf("v%0d_data_order", tag), bad_data, 0);
        check($sformatf("v%0d_word_count", tag), rx_idx, exp_words);
        check($sformatf("v%0d_wlast_position", tag), bad_wlast, 0);
        check($sformatf("v%0d_wlast_count", tag), wlast_cnt, n_aw);
        check($sformatf("v%0d_handshake_latency", tag), bad_timing, 0);
        check($sformatf("v%0d_start_cycles", tag), run_cyc, exp_run);
        check($sformatf("v%0d_status", tag), got_status, exp_status);

        src_valid = 1'b0;
        bvalid    = 1'b0;
        done_i    = 1'b0;
        @(negedge clk);
        check($sformatf("v%0d_status_pulse_width", tag), status_valid, 0);
        check($sformatf("v%0d_status_held", tag), status, exp_status);
        check($sformatf("v%0d_idle_after", tag), {busy, cmd_ready}, 2'b01);
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
        src_data = '0; src_valid = 1'b0;
        awready = 1'b0; wready = 1'b0;
        bid = '0; bresp = '0; bvalid = 1'b0;
        done_i = 1'b0; error_i = '0;

        #2;
        check("reset_awid_size_burst", {awid, awsize, awburst}, {4'h1, 3'd2, 2'd1});
        check("reset_aw_channel", {awvalid, awaddr, awlen}, 0);
        check("reset_w_channel", {wvalid, wlast, wstrb, wdata}, 0);
        check("reset_misc", {bready, start_o, busy, status, status_valid, cmd_ready, src_ready}, 0);

        @(negedge clk);
        rst = 1'b0;

        // Reset in the middle of a burst must drop every valid at once.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_addr = 32'h200; cmd_len = 16'd40;
        awready = 1'b1; wready = 1'b1; src_valid = 1'b1; src_data = 32'hA5A5_0001;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        #1 check("mid_w_active", wvalid, 1);
        rst = 1'b1;
        #1 check("mid_reset_drop", {awvalid, wvalid, bready, start_o, busy, src_ready}, 0);
        @(negedge clk);
        rst = 1'b0; awready = 1'b0; wready = 1'b0; src_valid = 1'b0;

        vecs.push_back('{32'h0000_0100, 40, -1, 3, 2'd0, 3, 0});
        vecs.push_back('{32'h0000_0FF8, 4, -1, 0, 2'd1, 2, 2});
        vecs.push_back('{32'h0000_0FF8, 4, 1, 0, 2'd0, 2, 1});
        vecs.push_back('{32'h0000_0000, 0, -1, 2, 2'd3, 0, 2});
        vecs.push_back('{32'h0000_03F3, 20, -1, 1, 2'd0, 2, 0});
        vecs.push_back('{32'h0000_0F00, 100, -1, 5, 2'd0, 7, 0});
`ifdef CGRA_LOADER_TIMEOUT_EN
        vecs.push_back('{32'h0000_0000, 0, -1, 1000, 2'd0, 0, 3});
        vecs.push_back('{32'h0000_0040, 2, -1, TimeoutCyc - 1, 2'd2, 1, 2});
`endif
        for (int i = 0; i < 8; i++) begin
            vec_t r;
            r.addr = 32'h1000 * $urandom_range(0, 3) + 4096 - 4 * $urandom_range(1, 40)
                     + $urandom_range(0, 3);
            r.len        = (i == 0) ? 100 : int'($urandom_range(0, 100));
            r.err_burst  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
            r.done_delay = $urandom_range(0, 15);
            r.cgra_err   = 2'($urandom);
            r.exp_bursts = -1;
            r.exp_status = -1;
            vecs.push_back(r);
        end

        for (int i = 0; i < vecs.size(); i++) run_txn(vecs[i], i);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
